crc_mem_scrub: RTL

CRC_MEM_SCRUB -- requirements
Module: crc_mem_scrub

---
 rtl/crc_mem_pkg.sv | 18 +
 rtl/crc_sat_cnt.sv | 22 ++
 rtl/crc_mem_scrub.sv | 128 ++++++++++++
 3 files changed

// File: rtl/crc_mem_pkg.sv
// Shared scrubber FSM state encoding and default width constants.
package crc_mem_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_RD_LAT     = 2;
  localparam int DEF_CNT_WIDTH  = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_WB    = 3'd4,
    S_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/crc_sat_cnt.sv
// Saturating up-counter with synchronous clear.
module crc_sat_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/crc_mem_scrub.sv
// Memory scrubber: walks every address, writes back corrected words and
// tallies corrected/uncorrectable CRC errors.
module crc_mem_scrub
  import crc_mem_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int RD_LAT     = DEF_RD_LAT,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic                  err_detected,
  input  logic                  err_corrected,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  corr_cnt,
  output logic [CNT_WIDTH-1:0]  uncorr_cnt,
  output logic [ADDR_WIDTH-1:0] first_uncorr_addr,
  output logic                  uncorr_seen
);

  localparam int WW = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(RD_LAT - 2);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [WW-1:0]         wait_cnt;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  corr_inc;
  logic                  uncorr_inc;
  logic                  cnt_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      addr              <= '0;
      wait_cnt          <= '0;
      wb_data           <= '0;
      first_uncorr_addr <= '0;
      uncorr_seen       <= 1'b0;
    end else if (abort) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            addr        <= '0;
            uncorr_seen <= 1'b0;
            state       <= S_RD;
          end
        end
        S_RD: begin
          wait_cnt <= '0;
          state    <= (RD_LAT > 1) ? S_WAIT : S_CHECK;
        end
        S_WAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            state <= S_CHECK;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          if (err_detected && err_corrected) begin
            wb_data <= mem_data_out;
            state   <= S_WB;
          end else begin
            if (err_detected && !uncorr_seen) begin
              first_uncorr_addr <= addr;
              uncorr_seen       <= 1'b1;
            end
            if (addr == '1) begin
              state <= S_DONE;
            end else begin
              addr  <= addr + 1'b1;
              state <= S_RD;
            end
          end
        end
        S_WB: begin
          if (addr == '1) begin
            state <= S_DONE;
          end else begin
            addr  <= addr + 1'b1;
            state <= S_RD;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign cnt_clr    = (state == S_IDLE) && start && !abort;
  assign corr_inc   = (state == S_CHECK) && err_detected && err_corrected && !abort;
  assign uncorr_inc = (state == S_CHECK) && err_detected && !err_corrected && !abort;

  crc_sat_cnt #(.WIDTH(CNT_WIDTH)) u_corr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (corr_inc),
    .cnt   (corr_cnt)
  );

  crc_sat_cnt #(.WIDTH(CNT_WIDTH)) u_uncorr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (uncorr_inc),
    .cnt   (uncorr_cnt)
  );

  // Write strobe and done are gated by abort so an abort cycle never commits.
  assign mem_wr      = (state == S_WB) && !abort;
  assign mem_data_in = (state == S_WB) ? wb_data : '0;
  assign mem_addr    = addr;
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE) && !abort;

endmodule
